mvm_sched: RTL and testbench
============================

MVM_SCHED -- requirements
Module: mvm_sched

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one mvm engine (2..8).
REQ-002 Parameter MATRIX_ROWS, default 3: matrix rows and result elements.
REQ-003 Parameter SHARED_DIM, default 3: matrix columns and vector elements.
REQ-004 Parameter WIDTH, default 8: element width in bits.
REQ-005 Parameter MVM_LATENCY, default 6: number of cycles from mvm_start until mvm_result is valid (min 1).
REQ-006 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port req_valid, input, NUM_REQ: per-requester job request.
REQ-009 Port req_ready, output, NUM_REQ: per-requester accept; at most one bit set.
REQ-010 Port req_matrix, input, NUM_REQ*MATRIX_ROWS*SHARED_DIM*WIDTH: per-requester flattened matrices; requester k occupies slice k.
REQ-011 Port req_vector, input, NUM_REQ*SHARED_DIM*WIDTH: per-requester flattened vectors; requester k occupies slice k.
REQ-012 Port resp_valid, output, NUM_REQ: result available for the owning requester.
REQ-013 Port resp_ready, input, NUM_REQ: per-requester result accept.
REQ-014 Port resp_data, output, MATRIX_ROWS*WIDTH: result vector shared by all requesters; qualified by resp_valid.
REQ-015 Ports mvm_reset and mvm_start, output, 1 each: engine control.
REQ-016 Ports mvm_matrix (MATRIX_ROWS*SHARED_DIM*WIDTH) and mvm_vector (SHARED_DIM*WIDTH), output: engine operands.
REQ-017 Port mvm_result, input, MATRIX_ROWS*WIDTH: engine result.
REQ-018 Ports perf_jobs and perf_busy, output, 32 each: performance counters (see Configuration).

Function
REQ-019 FSM states: IDLE, CLR, START, WAIT, DONE.
REQ-020 In IDLE, req_ready SHALL combinationally select the first set req_valid bit, searching round-robin from rr_ptr upward with wrap-around; req_ready is 0 in every other state.
REQ-021 Accept = req_valid[k] & req_ready[k]; on accept: latch k as owner, register slice k of req_matrix/req_vector onto mvm_matrix/mvm_vector, set rr_ptr to (k+1) mod NUM_REQ, go to CLR.
REQ-022 Requesters may drop req_valid before accept with no side effect; operands need only be stable in the accept cycle.
REQ-023 CLR: mvm_reset=1 for exactly one cycle, then START.
REQ-024 START: mvm_start=1 for exactly one cycle, load the wait counter, then WAIT.
REQ-025 WAIT: last exactly MVM_LATENCY cycles; capture mvm_result into resp_data in the final WAIT cycle, then DONE.
REQ-026 Timing, with accept in cycle 0: CLR in cycle 1, START in cycle 2, resp_valid[owner] first high in cycle 3+MVM_LATENCY.
REQ-027 DONE: hold resp_valid[owner] and resp_data stable until resp_ready[owner]=1, then return to IDLE; no new accept is possible before the cycle after return.
REQ-028 resp_ready bits for non-owners are ignored; only one resp_valid bit is ever set.
REQ-029 mvm_matrix and mvm_vector SHALL hold their values from the accept until the next accept.
REQ-030 Arithmetic is performed entirely by the engine; resp_data is the unmodified capture of mvm_result.

Reset
REQ-031 While reset=1, in the following cycle: state=IDLE, rr_ptr=0, resp_valid=0, resp_data=0, mvm_matrix=0, mvm_vector=0, mvm_start=0, mvm_reset=1.
REQ-032 Reset in any state aborts the job in progress without a response; the first cycle after reset deasserts accepts requests normally.

Configuration
REQ-033 Macro MVM_SCHED_PERF_EN defined: perf_jobs increments on each response handshake; perf_busy increments on every cycle not in IDLE; both clear on reset and saturate at 2^32-1.
REQ-034 Macro MVM_SCHED_PERF_EN undefined: perf_jobs and perf_busy are constant 0 and no counter logic is generated.

Verification
REQ-035 MVM_LATENCY=6, 3x3 engine: req0 sends matrix 010203040506070809, vector 010203 -> mvm_reset in cycle 1, mvm_start in cycle 2, resp_valid[0] in cycle 9, resp_data 0E2032.
REQ-036 req0 and req1 asserted together after reset (req1 sends 0A0B0C0D0E0F101111, vector 040506) -> req0 served first (0E2032), then req1 (A7D4FB on resp_valid[1]).
REQ-037 req0 and req1 held high for 6 jobs -> grants alternate 0,1,0,1,0,1; req_ready is never asserted outside IDLE.
REQ-038 resp_ready[0] held low for 10 cycles in DONE -> resp_valid[0] and resp_data remain stable, req_ready stays 0, and the job completes on the first cycle resp_ready[0]=1.
REQ-039 reset pulsed in the third WAIT cycle -> next cycle all outputs at reset values and mvm_reset=1; a fresh request then completes with the correct result.
REQ-040 With MVM_SCHED_PERF_EN defined, 2 back-to-back jobs each with immediate resp_ready -> perf_jobs=2 and perf_busy=2*(3+MVM_LATENCY)=18; without the macro, both counters read 0.

Source files
------------

// File: rtl/mvm_sched.sv
// Shares one matrix-vector engine among NUM_REQ requesters using round-robin arbitration.
// Optional performance counters are built only when MVM_SCHED_PERF_EN is defined.
module mvm_sched #(
    parameter int NUM_REQ     = 2,
    parameter int MATRIX_ROWS = 3,
    parameter int SHARED_DIM  = 3,
    parameter int WIDTH       = 8,
    parameter int MVM_LATENCY = 6
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_REQ-1:0]                             req_valid,
    output logic [NUM_REQ-1:0]                             req_ready,
    input  logic [NUM_REQ*MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] req_matrix,
    input  logic [NUM_REQ*SHARED_DIM*WIDTH-1:0]            req_vector,
    output logic [NUM_REQ-1:0]                             resp_valid,
    input  logic [NUM_REQ-1:0]                             resp_ready,
    output logic [MATRIX_ROWS*WIDTH-1:0]                   resp_data,
    output logic                                           mvm_reset,
    output logic                                           mvm_start,
    output logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0]        mvm_matrix,
    output logic [SHARED_DIM*WIDTH-1:0]                    mvm_vector,
    input  logic [MATRIX_ROWS*WIDTH-1:0]                   mvm_result,
    output logic [31:0]                                    perf_jobs,
    output logic [31:0]                                    perf_busy,
    output logic [2:0]                                     dbg_state_o
);

    localparam int MW = MATRIX_ROWS * SHARED_DIM * WIDTH;
    localparam int VW = SHARED_DIM * WIDTH;
    localparam int RW = MATRIX_ROWS * WIDTH;
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MVM_LATENCY + 1);
    localparam logic [CW-1:0] LAT_M1 = CW'(MVM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, CLR, START, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   grant_idx;
    logic            grant_found;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [MW-1:0]   mat_q, mat_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [RW-1:0]   res_q, res_d;
    logic            mvm_reset_q;

    // Round-robin search: first requester at or above rr_ptr, else lowest index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[k] && (IW'(k) >= rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IW'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(k);
            end
        end
    end

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // ready is offered only in IDLE (request side) and valid only in DONE (response side).
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        wait_cnt_d = wait_cnt_q;
        mat_d      = mat_q;
        vec_d      = vec_q;
        res_d      = res_q;
        req_ready  = '0;
        resp_valid = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (IW'(k) == grant_idx) begin
                            mat_d = req_matrix[k*MW +: MW];
                            vec_d = req_vector[k*VW +: VW];
                        end
                    end
                    state_d = CLR;
                end
            end
            CLR:   state_d = START;
            START: begin
                wait_cnt_d = LAT_M1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    res_d   = mvm_result;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            DONE: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            wait_cnt_q  <= '0;
            mat_q       <= '0;
            vec_q       <= '0;
            res_q       <= '0;
            mvm_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            mat_q       <= mat_d;
            vec_q       <= vec_d;
            res_q       <= res_d;
            mvm_reset_q <= (state_d == CLR);
        end
    end

    assign mvm_reset   = mvm_reset_q;
    assign mvm_start   = (state_q == START);
    assign mvm_matrix  = mat_q;
    assign mvm_vector  = vec_q;
    assign resp_data   = res_q;
    assign dbg_state_o = state_q;

`ifdef MVM_SCHED_PERF_EN
    logic [31:0] jobs_q, busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            jobs_q <= '0;
            busy_q <= '0;
        end else begin
            if ((state_q == DONE) && resp_ready[owner_q] && (jobs_q != '1)) jobs_q <= jobs_q + 1'b1;
            if ((state_q != IDLE) && (busy_q != '1)) busy_q <= busy_q + 1'b1;
        end
    end

    assign perf_jobs = jobs_q;
    assign perf_busy = busy_q;
`else
    assign perf_jobs = '0;
    assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_mvm_sched.sv
// Bench for mvm_sched: a cycle-level reference model checked every cycle plus directed
// scenarios with hand-computed literal expectations.
module tb_mvm_sched;

    localparam int N  = 2;
    localparam int R  = 3;
    localparam int S  = 3;
    localparam int W  = 8;
    localparam int L  = 6;
    localparam int MW = R * S * W;
    localparam int VW = S * W;
    localparam int RW = R * W;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*MW-1:0] req_matrix;
    logic [N*VW-1:0] req_vector;
    logic [RW-1:0]   resp_data, mvm_result;
    logic            mvm_reset, mvm_start;
    logic [MW-1:0]   mvm_matrix;
    logic [VW-1:0]   mvm_vector;
    logic [31:0]     perf_jobs, perf_busy;
    logic [2:0]      dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mvm_sched #(.NUM_REQ(N), .MATRIX_ROWS(R), .SHARED_DIM(S), .WIDTH(W), .MVM_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_matrix(req_matrix), .req_vector(req_vector),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mvm_reset(mvm_reset), .mvm_start(mvm_start),
        .mvm_matrix(mvm_matrix), .mvm_vector(mvm_vector), .mvm_result(mvm_result),
        .perf_jobs(perf_jobs), .perf_busy(perf_busy), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Element (i,j) of the matrix sits most-significant first, as do vector and result elements.
    function automatic logic [RW-1:0] mvm(input logic [MW-1:0] m, input logic [VW-1:0] v);
        logic [RW-1:0] r;
        logic [W-1:0]  acc;
        r = '0;
        for (int i = 0; i < R; i++) begin
            acc = '0;
            for (int j = 0; j < S; j++)
                acc = acc + m[(R*S-1-(i*S+j))*W +: W] * v[(S-1-j)*W +: W];
            r[(R-1-i)*W +: W] = acc;
        end
        return r;
    endfunction

    // ---------------- behavioural engine ----------------
    logic [RW-1:0] eng_res;
    int            eng_cnt = 0;
    always @(posedge clk) begin
        if (mvm_reset) eng_cnt <= 0;
        else if (mvm_start) begin
            eng_cnt <= 1;
            eng_res <= mvm(mvm_matrix, mvm_vector);
        end else if (eng_cnt > 0 && eng_cnt < L) eng_cnt <= eng_cnt + 1;
    end
    assign mvm_result = (eng_cnt >= L) ? eng_res : {R{8'hEE}};

    // ---------------- reference model + per-cycle compare ----------------
    int            m_busy, m_c, m_owner, m_rr, m_first, m_jobs, m_bcnt;
    logic [MW-1:0] m_mat;
    logic [VW-1:0] m_vec;
    logic [RW-1:0] m_res, m_data;
    int            grant_log[$];
    int            rown_log[$];
    logic [RW-1:0] rdat_log[$];
    logic [W-1:0]  exp_q[$];

    always @(negedge clk) begin
        int           g, k;
        logic [N-1:0] e_ready, e_valid;
        logic [31:0]  e_jobs, e_busy;
        if (reset) begin
            m_busy = 0; m_c = 0; m_owner = 0; m_rr = 0; m_first = 1;
            m_jobs = 0; m_bcnt = 0;
            m_mat = '0; m_vec = '0; m_res = '0; m_data = '0;
        end else begin
            g = -1;
            if (m_busy == 0) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_rr + i) % N;
                    if (g < 0 && req_valid[k]) g = k;
                end
            end
            e_ready = '0;
            if (g >= 0) e_ready[g] = 1'b1;
            if (m_busy != 0 && m_c == 3 + L) m_data = m_res;
            e_valid = '0;
            if (m_busy != 0 && m_c >= 3 + L) e_valid[m_owner] = 1'b1;
`ifdef MVM_SCHED_PERF_EN
            e_jobs = 32'(m_jobs);
            e_busy = 32'(m_bcnt);
`else
            e_jobs = '0;
            e_busy = '0;
`endif
            chk("req_ready", 128'(req_ready), 128'(e_ready));
            chk("resp_valid", 128'(resp_valid), 128'(e_valid));
            chk("resp_data", 128'(resp_data), 128'(m_data));
            chk("mvm_reset", 128'(mvm_reset), 128'((m_busy != 0 && m_c == 1) || (m_busy == 0 && m_first != 0)));
            chk("mvm_start", 128'(mvm_start), 128'(m_busy != 0 && m_c == 2));
            chk("mvm_matrix", 128'(mvm_matrix), 128'(m_mat));
            chk("mvm_vector", 128'(mvm_vector), 128'(m_vec));
            chk("perf_jobs", 128'(perf_jobs), 128'(e_jobs));
            chk("perf_busy", 128'(perf_busy), 128'(e_busy));

            // observed DUT handshakes for the directed scenarios
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
                if (resp_valid[i] && resp_ready[i]) begin
                    rown_log.push_back(i);
                    rdat_log.push_back(resp_data);
                end
            end

            if (m_busy != 0) m_bcnt++;
            m_first = 0;
            if (m_busy == 0) begin
                if (g >= 0) begin
                    m_busy  = 1;
                    m_c     = 1;
                    m_owner = g;
                    m_rr    = (g + 1) % N;
                    m_mat   = req_matrix[g*MW +: MW];
                    m_vec   = req_vector[g*VW +: VW];
                    m_res   = mvm(m_mat, m_vec);
                end
            end else if (m_c >= 3 + L && resp_ready[m_owner]) begin
                m_busy = 0;
                m_jobs++;
            end else begin
                m_c++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [MW-1:0] m, input logic [VW-1:0] v);
        req_matrix[k*MW +: MW] = m;
        req_vector[k*VW +: VW] = v;
    endtask

    task automatic wait_resps(input int n, input int budget, input string name);
        int t = 0;
        while (rown_log.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, 128'(rown_log.size() >= n), 128'(1));
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int t = 0;
        while (grant_log.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, 128'(grant_log.size() >= n), 128'(1));
    endtask

    // ---------------- directed scenarios ----------------
    localparam logic [MW-1:0] MAT0 = 72'h010203040506070809;
    localparam logic [VW-1:0] VEC0 = 24'h010203;
    localparam logic [MW-1:0] MAT1 = 72'h0A0B0C0D0E0F101111;
    localparam logic [VW-1:0] VEC1 = 24'h040506;
    localparam logic [RW-1:0] RES0 = 24'h0E2032;
    localparam logic [RW-1:0] RES1 = 24'hA7D4FB;

    initial begin
        int            t0, tr, ts, tv, base, gbase, sz;
        logic [RW-1:0] d;
        logic [2:0]    st0;

        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '1;
        req_matrix = '0;
        req_vector = '0;
        tick(); tick(); tick();
        reset = 1'b0;
        set_req(0, MAT0, VEC0);
        set_req(1, MAT1, VEC1);

        // model sanity: hand-computed products
        chk("model_res0", 128'(mvm(MAT0, VEC0)), 128'(RES0));
        chk("model_res1", 128'(mvm(MAT1, VEC1)), 128'(RES1));

        // reset values in the first cycle after reset
        @(negedge clk);
        chk("rst_mvm_reset", 128'(mvm_reset), 128'(1));
        chk("rst_resp_data", 128'(resp_data), 128'(0));
        chk("rst_mvm_matrix", 128'(mvm_matrix), 128'(0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_mvm_start", 128'(mvm_start), 128'(0));

        // single job timing
        tick();
        req_valid = 2'b01;
        t0 = -1; tr = -1; ts = -1; tv = -1; d = '0;
        for (int n = 0; n < 30 && tv < 0; n++) begin
            @(negedge clk);
            if (t0 < 0) begin
                if (req_ready[0]) t0 = cyc;
            end else begin
                if (mvm_reset && tr < 0) tr = cyc - t0;
                if (mvm_start && ts < 0) ts = cyc - t0;
                if (resp_valid[0]) begin
                    tv = cyc - t0;
                    d  = resp_data;
                end
            end
            tick();
            if (t0 >= 0) req_valid = '0;
        end
        req_valid = '0;
        chk("t_mvm_reset", 128'(tr), 128'(1));
        chk("t_mvm_start", 128'(ts), 128'(2));
        chk("t_resp_valid", 128'(tv), 128'(3 + L));
        chk("job0_data", 128'(d), 128'(RES0));

        // simultaneous requests after reset
        do_reset();
        base = rown_log.size();
        req_valid = 2'b11;
        wait_resps(base + 2, 60, "two_req_timeout");
        req_valid = '0;
        if (rown_log.size() >= base + 2) begin
            chk("two_req_owner_a", 128'(rown_log[base]), 128'(0));
            chk("two_req_data_a", 128'(rdat_log[base]), 128'(RES0));
            chk("two_req_owner_b", 128'(rown_log[base + 1]), 128'(1));
            chk("two_req_data_b", 128'(rdat_log[base + 1]), 128'(RES1));
        end

        // fairness over six jobs
        do_reset();
        base  = rown_log.size();
        gbase = grant_log.size();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(W'(i % 2));
        req_valid = 2'b11;
        wait_resps(base + 6, 120, "rr_timeout");
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            if (grant_log.size() > gbase + i && exp_q.size() > 0)
                chk("rr_grant", 128'(grant_log[gbase + i]), 128'(exp_q.pop_front()));
        end

        // back-pressure in DONE (non-owner resp_ready high and ignored)
        do_reset();
        base  = rown_log.size();
        gbase = grant_log.size();
        resp_ready = 2'b10;
        req_valid  = 2'b11;
        wait_grants(gbase + 1, 10, "stall_grant_timeout");
        req_valid = 2'b10;
        tv = -1;
        for (int n = 0; n < 30 && tv < 0; n++) begin
            @(negedge clk);
            if (resp_valid[0]) tv = n;
            else tick();
        end
        chk("stall_valid_seen", 128'(tv >= 0), 128'(1));
        st0 = dbg_state;
        for (int i = 0; i < 10; i++) begin
            chk("stall_resp_valid", 128'(resp_valid), 128'(2'b01));
            chk("stall_resp_data", 128'(resp_data), 128'(RES0));
            chk("stall_req_ready", 128'(req_ready), 128'(0));
            chk("stall_state_hold", 128'(dbg_state), 128'(st0));
            tick();
            @(negedge clk);
        end
        tick();
        resp_ready = 2'b11;
        @(negedge clk);
        chk("release_valid", 128'(resp_valid), 128'(2'b01));
        tick();
        @(negedge clk);
        chk("release_done", 128'(resp_valid), 128'(0));
        chk("release_next_grant", 128'(req_ready), 128'(2'b10));
        tick();
        req_valid = '0;
        wait_resps(base + 2, 40, "stall_timeout");
        if (rown_log.size() >= base + 2) begin
            chk("stall_owner", 128'(rown_log[base]), 128'(0));
            chk("after_stall_data", 128'(rdat_log[base + 1]), 128'(RES1));
        end

        // reset in the third WAIT cycle aborts the job
        sz = rown_log.size();
        req_valid = 2'b01;
        t0 = -1;
        for (int n = 0; n < 20 && t0 < 0; n++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) t0 = cyc;
            tick();
        end
        chk("abort_accept_seen", 128'(t0 >= 0), 128'(1));
        req_valid = '0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_resp_valid", 128'(resp_valid), 128'(0));
        chk("abort_resp_data", 128'(resp_data), 128'(0));
        chk("abort_mvm_matrix", 128'(mvm_matrix), 128'(0));
        chk("abort_mvm_vector", 128'(mvm_vector), 128'(0));
        chk("abort_mvm_start", 128'(mvm_start), 128'(0));
        chk("abort_mvm_reset", 128'(mvm_reset), 128'(1));
        chk("abort_no_resp", 128'(rown_log.size()), 128'(sz));
        tick();
        base = rown_log.size();
        req_valid = 2'b10;
        wait_grants(grant_log.size() + 1, 10, "fresh_grant_timeout");
        req_valid = '0;
        wait_resps(base + 1, 40, "fresh_timeout");
        if (rown_log.size() >= base + 1) begin
            chk("fresh_owner", 128'(rown_log[base]), 128'(1));
            chk("fresh_data", 128'(rdat_log[base]), 128'(RES1));
        end

        // performance counters over two back-to-back jobs
        do_reset();
        base = rown_log.size();
        req_valid = 2'b01;
        wait_resps(base + 2, 60, "perf_timeout");
        req_valid = '0;
        @(negedge clk);
`ifdef MVM_SCHED_PERF_EN
        chk("perf_jobs_final", 128'(perf_jobs), 128'(2));
        chk("perf_busy_final", 128'(perf_busy), 128'(18));
`else
        chk("perf_jobs_final", 128'(perf_jobs), 128'(0));
        chk("perf_busy_final", 128'(perf_busy), 128'(0));
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
